// File: rtl/phy_rx_lane_aligner.sv
// rtl/phy_rx_lane_aligner.sv - serial word aligner with comma lock qualification and round-robin lane fan-out
module phy_rx_lane_aligner #(
    parameter int               WIDTH      = 8,
    parameter int               LANES      = 4,
    parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
    parameter int               LOCK_COUNT = 4
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    input  logic                   resync,
    input  logic                   data_in,
    output logic                   active,
    output logic [WIDTH-1:0]       word_out,
    output logic                   word_valid,
    output logic [LANES*WIDTH-1:0] lane_data,
    output logic [LANES-1:0]       lane_valid
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int KW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [KW-1:0]    comma_cnt;
    logic [LW-1:0]    lane_ptr;
    logic             is_comma;
    logic             word_check;
    logic             hunt_hit;
    logic             lock_comma;
    logic             deliver;

    assign is_comma   = (shreg == COMMA);
    assign word_check = (bit_cnt == CW'(WIDTH)) && (state != HUNT);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (resync) begin
            state_nxt = HUNT;
        end else begin
            case (state)
                HUNT: begin
                    if (is_comma) begin
                        state_nxt = (LOCK_COUNT == 1) ? LOCKED : SYNC;
                    end
                end
                SYNC: begin
                    if (word_check) begin
                        if (!is_comma) begin
                            state_nxt = HUNT;
                        end else if (comma_cnt == KW'(LOCK_COUNT - 1)) begin
                            state_nxt = LOCKED;
                        end
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // resync masks every event of its cycle, including a coincident word check
    always_comb begin
        hunt_hit   = 1'b0;
        lock_comma = 1'b0;
        deliver    = 1'b0;
        if (!resync) begin
            hunt_hit   = (state == HUNT) && is_comma;
            lock_comma = (state == LOCKED) && word_check && is_comma;
            deliver    = (state == LOCKED) && word_check && !is_comma;
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            comma_cnt  <= '0;
            lane_ptr   <= '0;
            active     <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            lane_data  <= '0;
            lane_valid <= '0;
        end else begin
            shreg      <= {shreg[WIDTH-2:0], data_in};
            active     <= (state_nxt == LOCKED);
            word_valid <= deliver;
            lane_valid <= deliver ? (LANES'(1) << lane_ptr) : '0;

            // bit_cnt free-runs in HUNT; its value only matters once aligned
            if (resync) begin
                bit_cnt <= '0;
            end else if (hunt_hit || word_check) begin
                bit_cnt <= CW'(1);
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (resync) begin
                comma_cnt <= '0;
            end else if (hunt_hit) begin
                comma_cnt <= KW'(1);
            end else if ((state == SYNC) && word_check) begin
                comma_cnt <= is_comma ? comma_cnt + 1'b1 : '0;
            end

            if (resync || lock_comma) begin
                lane_ptr <= '0;
            end else if (deliver) begin
                lane_ptr <= (lane_ptr == LW'(LANES - 1)) ? '0 : lane_ptr + 1'b1;
            end

            if (deliver) begin
                word_out <= shreg;
                for (int i = 0; i < LANES; i++) begin
                    if (lane_ptr == LW'(i)) begin
                        lane_data[i*WIDTH +: WIDTH] <= shreg;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_phy_rx_lane_aligner.sv
// tb/tb_phy_rx_lane_aligner.sv - bench for phy_rx_lane_aligner at 8b/4 lanes and 10b/2 lanes
module tb_phy_rx_lane_aligner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rs8, din8, rs10, din10;
    logic        act8, wv8, act10, wv10;
    logic [7:0]  wo8;
    logic [31:0] ld8;
    logic [3:0]  lv8;
    logic [9:0]  wo10;
    logic [19:0] ld10;
    logic [1:0]  lv10;

    phy_rx_lane_aligner #(.WIDTH(8), .LANES(4), .COMMA(8'hBC), .LOCK_COUNT(4)) u8 (
        .clk_32f(clk), .reset(rst_n), .resync(rs8), .data_in(din8), .active(act8),
        .word_out(wo8), .word_valid(wv8), .lane_data(ld8), .lane_valid(lv8));

    phy_rx_lane_aligner #(.WIDTH(10), .LANES(2), .COMMA(10'h17C), .LOCK_COUNT(1)) u10 (
        .clk_32f(clk), .reset(rst_n), .resync(rs10), .data_in(din10), .active(act10),
        .word_out(wo10), .word_valid(wv10), .lane_data(ld10), .lane_valid(lv10));

    localparam int M_HUNT = 0;
    localparam int M_SYNC = 1;
    localparam int M_LOCK = 2;
    localparam int HIST   = 16384;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int rst_at = 0;

    int mw  [2] = '{8, 10};
    int ml  [2] = '{4, 2};
    int mlc [2] = '{4, 1};
    int mcm [2] = '{'hBC, 'h17C};

    // reference: sampled bit history by edge index, alignment as an edge-index phase
    bit bits [2][0:HIST-1];
    int mode [2], anchor [2], ccnt [2], lane [2];
    int e_act [2], e_wv [2], e_wo [2], e_lv [2];
    int e_ld  [2][4];

    typedef struct { int val; int lane; int at; } ev_t;
    ev_t log8 [$];
    ev_t log10 [$];

    typedef struct { logic [7:0] word; bit rs_before; int exp_lane; } vec_t;
    vec_t tbl [$];

    int cur [2], bp [2], pre [2];

    function automatic int window(input int i);
        int v;
        int idx;
        v = 0;
        for (int j = mw[i]; j >= 1; j--) begin
            idx = cyc - j;
            v = v * 2 + ((idx >= rst_at) ? int'(bits[i][idx % HIST]) : 0);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = M_HUNT; anchor[i] = 0; ccnt[i] = 0; lane[i] = 0;
            e_act[i] = 0; e_wv[i] = 0; e_wo[i] = 0; e_lv[i] = 0;
            for (int k = 0; k < 4; k++) e_ld[i][k] = 0;
        end
    endtask

    task automatic model_edge(input int i, input bit d, input bit r);
        int  w;
        bit  chk;
        w   = window(i);
        chk = (cyc > anchor[i]) && (((cyc - anchor[i]) % mw[i]) == 0);
        e_wv[i] = 0;
        e_lv[i] = 0;
        if (r) begin
            mode[i] = M_HUNT; ccnt[i] = 0; lane[i] = 0;
        end else if (mode[i] == M_HUNT) begin
            if (w == mcm[i]) begin
                anchor[i] = cyc;
                ccnt[i]   = 1;
                mode[i]   = (mlc[i] == 1) ? M_LOCK : M_SYNC;
            end
        end else if (chk) begin
            if (mode[i] == M_SYNC) begin
                if (w == mcm[i]) begin
                    ccnt[i]++;
                    if (ccnt[i] == mlc[i]) mode[i] = M_LOCK;
                end else begin
                    mode[i] = M_HUNT;
                    ccnt[i] = 0;
                end
            end else if (w == mcm[i]) begin
                lane[i] = 0;
            end else begin
                e_wv[i] = 1;
                e_wo[i] = w;
                e_lv[i] = 1 << lane[i];
                e_ld[i][lane[i]] = w;
                lane[i] = (lane[i] + 1) % ml[i];
            end
        end
        e_act[i] = (mode[i] == M_LOCK) ? 1 : 0;
        bits[i][cyc % HIST] = d;
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = -1;
        if ($onehot(v)) begin
            for (int k = 0; k < 4; k++) if (v[k]) r = k;
        end
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        logic [55:0] got;
        logic [55:0] exp;
        logic [39:0] lexp;
        for (int i = 0; i < 2; i++) begin
            lexp = '0;
            for (int k = 0; k < ml[i]; k++) lexp = lexp | (40'(e_ld[i][k]) << (k * mw[i]));
            exp = {1'(e_act[i]), 1'(e_wv[i]), 10'(e_wo[i]), 4'(e_lv[i]), lexp};
            if (i == 0) got = {act8, wv8, 2'b00, wo8, lv8, 8'h00, ld8};
            else        got = {act10, wv10, wo10, 2'b00, lv10, 20'h0, ld10};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", tag, i, cyc, got, exp);
            end
        end
    endtask

    task automatic expect_eq(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic step(input bit d8, input bit r8, input bit d10, input bit r10);
        din8 = d8; rs8 = r8; din10 = d10; rs10 = r10;
        @(posedge clk);
        if (rst_n) begin
            model_edge(0, d8, r8);
            model_edge(1, d10, r10);
        end
        cyc++;
        #1;
        check_outputs("model");
        if (wv8)  log8.push_back('{int'(wo8), onehot_idx(lv8), cyc});
        if (wv10) log10.push_back('{int'(wo10), onehot_idx({2'b00, lv10}), cyc});
    endtask

    task automatic send8(input logic [7:0] w);
        for (int b = 7; b >= 0; b--) step(w[b], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send10(input logic [9:0] w);
        for (int b = 9; b >= 0; b--) step(1'b0, 1'b0, w[b], 1'b0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        expect_eq("reset_lane_data8", ld8, 0);
        expect_eq("reset_word_out8", wo8, 0);
        expect_eq("reset_active8", act8, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        rst_at = cyc;
    endtask

    task automatic apply_tbl(input int lo, input int hi);
        for (int t = lo; t <= hi; t++) begin
            if (tbl[t].rs_before) step(1'b0, 1'b1, 1'b0, 1'b0);
            send8(tbl[t].word);
        end
    endtask

    task automatic gen_bit(input int i, output bit b);
        if (bp[i] == 0) begin
            if (pre[i] > 0) begin
                pre[i]--;
                cur[i] = mcm[i];
            end else if ($urandom_range(0, 9) < 3) begin
                cur[i] = mcm[i];
            end else begin
                cur[i] = int'($urandom_range(0, (1 << mw[i]) - 1));
            end
            bp[i] = mw[i];
        end
        bp[i]--;
        b = bit'((cur[i] >> bp[i]) & 1);
    endtask

    initial begin
        int k;
        int c0;
        rst_n = 1'b0; rs8 = 1'b0; din8 = 1'b0; rs10 = 1'b0; din10 = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n  = 1'b1;
        rst_at = cyc;

        tbl.push_back('{8'hBC, 1'b0, -1}); tbl.push_back('{8'hBC, 1'b0, -1});
        tbl.push_back('{8'hBC, 1'b0, -1}); tbl.push_back('{8'hBC, 1'b0, -1});
        tbl.push_back('{8'h11, 1'b0, 0});  tbl.push_back('{8'h22, 1'b0, 1});
        tbl.push_back('{8'h33, 1'b0, 2});  tbl.push_back('{8'h44, 1'b0, 3});
        tbl.push_back('{8'h55, 1'b0, 0});  tbl.push_back('{8'hBC, 1'b0, -1});
        tbl.push_back('{8'hBC, 1'b1, -1}); tbl.push_back('{8'hBC, 1'b0, -1});
        tbl.push_back('{8'h3C, 1'b0, -1}); tbl.push_back('{8'hBC, 1'b0, -1});
        tbl.push_back('{8'hBC, 1'b0, -1}); tbl.push_back('{8'hBC, 1'b0, -1});
        tbl.push_back('{8'hBC, 1'b0, -1}); tbl.push_back('{8'hA5, 1'b0, 0});
        tbl.push_back('{8'hBC, 1'b0, -1}); tbl.push_back('{8'h01, 1'b0, 0});
        tbl.push_back('{8'h02, 1'b0, 1});  tbl.push_back('{8'hBC, 1'b0, -1});
        tbl.push_back('{8'h03, 1'b0, 0});  tbl.push_back('{8'hBC, 1'b0, -1});

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        apply_tbl(0, 9);
        expect_eq("lanes_after_first_burst", ld8, 32'h44332255);
        expect_eq("active_after_lock", act8, 1);
        apply_tbl(10, tbl.size() - 1);

        k = 0;
        for (int t = 0; t < tbl.size(); t++) begin
            if (tbl[t].exp_lane >= 0) begin
                if (k < log8.size()) begin
                    expect_eq("tbl_word", log8[k].val, tbl[t].word);
                    expect_eq("tbl_lane", log8[k].lane, tbl[t].exp_lane);
                end
                k++;
            end
        end
        expect_eq("tbl_strobe_count", log8.size(), k);
        if (log8.size() >= 5) begin
            for (int g = 1; g < 5; g++) expect_eq("burst_gap", log8[g].at - log8[g-1].at, 8);
        end

        // resync in the middle of a word while locked
        log8.delete();
        expect_eq("locked_before_resync", act8, 1);
        for (int b = 7; b >= 0; b--) begin
            step(bit'((8'h66 >> b) & 1), (b == 3), 1'b0, 1'b0);
            if (b == 3) expect_eq("resync_active_fall", act8, 0);
        end
        send8(8'hBC); send8(8'hBC); send8(8'hBC);
        expect_eq("relock_needs_four", act8, 0);
        send8(8'hBC); send8(8'h77); send8(8'hBC);
        expect_eq("relock_active", act8, 1);
        expect_eq("resync_strobe_count", log8.size(), 1);
        if (log8.size() >= 1) begin
            expect_eq("relock_word", log8[0].val, 8'h77);
            expect_eq("relock_lane", log8[0].lane, 0);
        end

        // asynchronous reset in the middle of a word while lanes hold data
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        log8.delete();
        send8(8'hBC); send8(8'hBC); send8(8'hBC); send8(8'hBC);
        send8(8'h7E); send8(8'hBC);
        expect_eq("post_reset_lanes", ld8, 32'h0000007E);
        expect_eq("post_reset_strobes", log8.size(), 1);

        // 10-bit, 2-lane, single-comma lock
        log10.delete();
        send10(10'h17C);
        c0 = cyc;
        send10(10'h2AA); send10(10'h155); send10(10'h3FF); send10(10'h17C);
        expect_eq("w10_active", act10, 1);
        expect_eq("w10_strobe_count", log10.size(), 3);
        if (log10.size() == 3) begin
            expect_eq("w10_word0", log10[0].val, 10'h2AA);
            expect_eq("w10_lane0", log10[0].lane, 0);
            expect_eq("w10_word1", log10[1].val, 10'h155);
            expect_eq("w10_lane1", log10[1].lane, 1);
            expect_eq("w10_word2", log10[2].val, 10'h3FF);
            expect_eq("w10_lane2", log10[2].lane, 0);
            expect_eq("w10_latency", log10[0].at - c0, 11);
            expect_eq("w10_gap", log10[1].at - log10[0].at, 10);
        end
        expect_eq("w10_lanes", ld10, {10'h155, 10'h3FF});

        // random traffic on both instances against the reference
        for (int i = 0; i < 2; i++) begin
            bp[i] = 0; cur[i] = 0; pre[i] = mlc[i] + 1;
        end
        for (int n = 0; n < 6000; n++) begin
            bit b0, b1, r0, r1;
            if (n == 3000) begin
                pulse_reset();
                for (int i = 0; i < 2; i++) begin
                    bp[i] = 0; pre[i] = mlc[i] + 1;
                end
            end
            gen_bit(0, b0);
            gen_bit(1, b1);
            r0 = ($urandom_range(0, 399) == 0);
            r1 = ($urandom_range(0, 399) == 0);
            if (r0) pre[0] = mlc[0] + 1;
            if (r1) pre[1] = mlc[1] + 1;
            step(b0, r0, b1, r1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
